// File: rtl/bytewrite_ram_arb_if.sv
// Requester-side bus of the shared byte-write RAM arbiter: per-requester
// request channel slices plus the shared read-response return path.
interface bytewrite_ram_arb_if #(
    parameter int AW   = 10,
    parameter int NB   = 4,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NB-1:0]   req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*NB*8-1:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [NB*8-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bytewrite_ram_arb.sv
// Round-robin arbiter sharing one single-port byte-write RAM between NREQ
// requesters. The granted request drives the RAM port combinationally; reads
// are tagged with the requester ID and travel down a RAM_LAT-deep pipe so the
// response strobe lines up with the RAM's registered read data.
module bytewrite_ram_arb #(
    parameter int AW      = 10,
    parameter int NB      = 4,
    parameter int NREQ    = 2,
    parameter int RAM_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    bytewrite_ram_arb_if.slave           bus,
    output logic [NB-1:0]                o_ram_we,
    output logic [AW-1:0]                o_ram_addr,
    output logic [NB*8-1:0]              o_ram_din,
    input  logic [NB*8-1:0]              i_ram_dout,
    output logic [$clog2(RAM_LAT+1)-1:0] o_rd_pending
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(RAM_LAT+1);

    logic [IDW-1:0] r_last;
    logic           w_found;
    logic [IDW-1:0] w_gid;
    logic           w_is_rd;
    logic           r_vld_p [RAM_LAT];
    logic [IDW-1:0] r_id_p  [RAM_LAT];

    // Pick the first valid requester after the last one served, wrapping; nothing under reset
    always_comb begin
        int             v_idx;
        logic [IDW-1:0] v_sel;
        w_found = 1'b0;
        w_gid   = '0;
        v_idx   = 0;
        v_sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = int'(r_last) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            v_sel = IDW'(v_idx);
            if (!w_found && bus.req_valid[v_sel]) begin
                w_found = 1'b1;
                w_gid   = v_sel;
            end
        end
        if (rst) begin
            w_found = 1'b0;
            w_gid   = '0;
        end
    end

    // Grant doubles as ready; the granted slice goes straight to the RAM port
    always_comb begin
        bus.req_ready = '0;
        o_ram_we      = '0;
        o_ram_addr    = '0;
        o_ram_din     = '0;
        w_is_rd       = 1'b0;
        if (w_found) begin
            bus.req_ready[w_gid] = 1'b1;
            o_ram_we             = bus.req_we[w_gid*NB +: NB];
            o_ram_addr           = bus.req_addr[w_gid*AW +: AW];
            o_ram_din            = bus.req_wdata[w_gid*NB*8 +: NB*8];
            w_is_rd              = (bus.req_we[w_gid*NB +: NB] == '0);
        end
    end

    // Remember who was served last; reset hands first priority to requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IDW'(NREQ-1);
        end else if (w_found) begin
            r_last <= w_gid;
        end
    end

    // Read-valid pipe, stage 0 loads on acceptance; cleared by reset so in-flight reads are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_vld_p[0] <= w_is_rd;
            for (int i = 1; i < RAM_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    // Requester-ID tags ride alongside the valid bits; only meaningful where valid is set
    always_ff @(posedge clk) begin
        r_id_p[0] <= w_gid;
        for (int i = 1; i < RAM_LAT; i++) r_id_p[i] <= r_id_p[i-1];
    end

    // Last pipe stage steers the unregistered RAM data back to its requester; count reads in flight
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        o_rd_pending  = '0;
        if (!rst) begin
            for (int i = 0; i < RAM_LAT; i++) o_rd_pending = o_rd_pending + PW'(r_vld_p[i]);
            if (r_vld_p[RAM_LAT-1]) begin
                bus.rsp_valid[r_id_p[RAM_LAT-1]] = 1'b1;
                bus.rsp_rdata                    = i_ram_dout;
            end
        end
    end
endmodule

// File: tb/tb_bytewrite_ram_arb.sv
// Directed bench for bytewrite_ram_arb with a 2-cycle byte-write RAM model.
module tb_bytewrite_ram_arb;
    localparam int AW      = 10;
    localparam int NB      = 4;
    localparam int NREQ    = 2;
    localparam int RAM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  w_ram_we;
    logic [9:0]  w_ram_addr;
    logic [31:0] w_ram_din;
    logic [31:0] w_ram_dout;
    logic [1:0]  w_rd_pending;

    int n_vec = 0;
    int n_err = 0;

    bytewrite_ram_arb_if #(.AW(AW), .NB(NB), .NREQ(NREQ)) bus ();

    bytewrite_ram_arb #(.AW(AW), .NB(NB), .NREQ(NREQ), .RAM_LAT(RAM_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .o_ram_we     (w_ram_we),
        .o_ram_addr   (w_ram_addr),
        .o_ram_din    (w_ram_din),
        .i_ram_dout   (w_ram_dout),
        .o_rd_pending (w_rd_pending)
    );

    always #5 clk = ~clk;

    // Single-port byte-write RAM, address sampled at the edge, data out two edges later
    logic [31:0] mem [0:1023];
    logic [31:0] ram_rd1;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (w_ram_we[b]) mem[w_ram_addr][b*8 +: 8] <= w_ram_din[b*8 +: 8];
        ram_rd1    <= mem[w_ram_addr];
        w_ram_dout <= ram_rd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int i, input logic v, input logic [3:0] we,
                       input logic [9:0] a, input logic [31:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i*NB +: NB]    = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held 3 cycles with everyone requesting writes
        rst = 1'b1;
        drv(0, 1'b1, 4'hF, 10'd1, 32'h0);
        drv(1, 1'b1, 4'hF, 10'd2, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready",   64'(bus.req_ready), 64'h0);
            chk("rst_ram_we",  64'(w_ram_we),      64'h0);
            chk("rst_rsp_vld", 64'(bus.rsp_valid), 64'h0);
            chk("rst_pending", 64'(w_rd_pending),  64'h0);
            nxt();
        end
        rst = 1'b0;
        drv(1, 1'b0, 4'h0, 10'd0, 32'h0);

        // full-word preload, then byte-masked write over it
        drv(0, 1'b1, 4'hF, 10'd5, 32'h11223344);
        @(negedge clk);
        chk("pre_ready", 64'(bus.req_ready), 64'h1);
        chk("pre_we",    64'(w_ram_we),      64'hF);
        chk("pre_din",   64'(w_ram_din),     64'h11223344);
        nxt();
        drv(0, 1'b1, 4'b0101, 10'd5, 32'hAABBCCDD);
        @(negedge clk);
        chk("bw_ready", 64'(bus.req_ready), 64'h1);
        chk("bw_we",    64'(w_ram_we),      64'h5);
        chk("bw_addr",  64'(w_ram_addr),    64'h5);
        nxt();
        drv(0, 1'b1, 4'h0, 10'd5, 32'h0);
        @(negedge clk);
        chk("rd_ready", 64'(bus.req_ready), 64'h1);
        chk("rd_we",    64'(w_ram_we),      64'h0);
        nxt();
        drv(0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        chk("rd_t1_vld",     64'(bus.rsp_valid), 64'h0);
        chk("rd_t1_pending", 64'(w_rd_pending),  64'h1);
        nxt();
        @(negedge clk);
        chk("rd_t2_vld",   64'(bus.rsp_valid), 64'h1);
        chk("rd_t2_data",  64'(bus.rsp_rdata), 64'h11BB33DD);
        nxt();
        @(negedge clk);
        chk("rd_t3_vld",  64'(bus.rsp_valid), 64'h0);
        chk("rd_t3_data", 64'(bus.rsp_rdata), 64'h0);

        // back-to-back write then read by requester 1 at the top address
        drv(1, 1'b1, 4'hF, 10'h3FF, 32'hDEADBEEF);
        @(negedge clk);
        chk("raw_w_ready", 64'(bus.req_ready), 64'h2);
        nxt();
        drv(1, 1'b1, 4'h0, 10'h3FF, 32'h0);
        @(negedge clk);
        chk("raw_r_ready", 64'(bus.req_ready), 64'h2);
        nxt();
        drv(1, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        chk("raw_t1_vld", 64'(bus.rsp_valid), 64'h0);
        nxt();
        @(negedge clk);
        chk("raw_t2_vld",  64'(bus.rsp_valid), 64'h2);
        chk("raw_t2_data", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        nxt();

        // both requesters writing every cycle: strict alternation from 0
        drv(0, 1'b1, 4'hF, 10'h100, 32'h0);
        drv(1, 1'b1, 4'hF, 10'h200, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(bus.req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
            chk("rr_addr",  64'(w_ram_addr),    (k % 2 == 1) ? 64'h200 : 64'h100);
            nxt();
        end
        drv(1, 1'b0, 4'h0, 10'h0, 32'h0);

        // fill 0..15, then stream 16 reads back
        for (int k = 0; k < 16; k++) begin
            drv(0, 1'b1, 4'hF, 10'(k), 32'hC0DE0000 + 32'(k));
            @(negedge clk);
            chk("fill_ready", 64'(bus.req_ready), 64'h1);
            nxt();
        end
        for (int k = 0; k < 19; k++) begin
            if (k < 16) drv(0, 1'b1, 4'h0, 10'(k), 32'h0);
            else        drv(0, 1'b0, 4'h0, 10'h0, 32'h0);
            @(negedge clk);
            if (k < 16) chk("st_ready", 64'(bus.req_ready), 64'h1);
            chk("st_pending", 64'(w_rd_pending),
                (k == 0 || k == 18) ? 64'h0 : ((k == 1 || k == 17) ? 64'h1 : 64'h2));
            chk("st_vld", 64'(bus.rsp_valid), (k >= 2 && k <= 17) ? 64'h1 : 64'h0);
            if (k >= 2 && k <= 17)
                chk("st_data", 64'(bus.rsp_rdata), 64'hC0DE0000 + 64'(k - 2));
            nxt();
        end

        // reset one cycle after a read is accepted: response must vanish
        drv(0, 1'b1, 4'h0, 10'd5, 32'h0);
        @(negedge clk);
        chk("mf_ready", 64'(bus.req_ready), 64'h1);
        nxt();
        drv(0, 1'b0, 4'h0, 10'd0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mf_rst_vld",     64'(bus.rsp_valid), 64'h0);
        chk("mf_rst_pending", 64'(w_rd_pending),  64'h0);
        nxt();
        rst = 1'b0;
        drv(0, 1'b1, 4'hF, 10'h300, 32'h0);
        drv(1, 1'b1, 4'hF, 10'h301, 32'h0);
        @(negedge clk);
        chk("mf_post_ready", 64'(bus.req_ready), 64'h1);
        chk("mf_post_vld",   64'(bus.rsp_valid), 64'h0);
        nxt();
        drv(0, 1'b0, 4'h0, 10'h0, 32'h0);
        drv(1, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        chk("mf_late_vld",     64'(bus.rsp_valid), 64'h0);
        chk("mf_late_pending", 64'(w_rd_pending),  64'h0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
